// File: rtl/alu_acc.sv
// Accumulator ALU stage: single-cycle logic/arith ops on an accumulator plus an
// iterative shift-add multiply, with start/busy/done handshake and rf write strobe.
module alu_acc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc_out,
    output logic             rf_wr,
    output logic             flag_z,
    output logic             flag_c
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_STA = 4'd10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     acc_r;
    logic                 flag_z_r;
    logic                 flag_c_r;
    logic                 done_r;
    logic                 busy_r;
    logic                 rf_wr_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     mplr_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [CW-1:0]        cnt_r;

    logic [WIDTH-1:0]     alu_acc_s;
    logic                 alu_z_s;
    logic                 alu_c_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   prod_step_s;

    assign acc_out = acc_r;
    assign flag_z  = flag_z_r;
    assign flag_c  = flag_c_r;
    assign done    = done_r;
    assign busy    = busy_r;
    assign rf_wr   = rf_wr_r;

    // Single-cycle result and flags for every non-multiply opcode
    always_comb begin
        alu_acc_s = acc_r;
        alu_z_s   = flag_z_r;
        alu_c_s   = flag_c_r;
        sum_s     = {1'b0, acc_r} + {1'b0, operand};
        case (op)
            OP_LDA: begin
                alu_acc_s = operand;
                alu_z_s   = (operand == {WIDTH{1'b0}});
            end
            OP_ADD: begin
                alu_acc_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_z_s   = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
            end
            OP_SUB: begin
                alu_acc_s = acc_r - operand;
                alu_c_s   = (operand > acc_r);
                alu_z_s   = (acc_r == operand);
            end
            OP_AND: begin
                alu_acc_s = acc_r & operand;
                alu_c_s   = 1'b0;
                alu_z_s   = ((acc_r & operand) == {WIDTH{1'b0}});
            end
            OP_OR: begin
                alu_acc_s = acc_r | operand;
                alu_c_s   = 1'b0;
                alu_z_s   = ((acc_r | operand) == {WIDTH{1'b0}});
            end
            OP_XOR: begin
                alu_acc_s = acc_r ^ operand;
                alu_c_s   = 1'b0;
                alu_z_s   = ((acc_r ^ operand) == {WIDTH{1'b0}});
            end
            OP_SHL: begin
                alu_acc_s = {acc_r[WIDTH-2:0], 1'b0};
                alu_c_s   = acc_r[WIDTH-1];
                alu_z_s   = (acc_r[WIDTH-2:0] == {(WIDTH-1){1'b0}});
            end
            OP_SHR: begin
                alu_acc_s = {1'b0, acc_r[WIDTH-1:1]};
                alu_c_s   = acc_r[0];
                alu_z_s   = (acc_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
            end
            default: begin
                alu_acc_s = acc_r;
                alu_z_s   = flag_z_r;
                alu_c_s   = flag_c_r;
            end
        endcase
    end

    // One shift-add step: add the multiplicand, shifted to the current bit weight
    always_comb begin
        prod_step_s = prod_r + (mplr_r[0] ? ({{WIDTH{1'b0}}, mcand_r} << cnt_r)
                                          : {(2*WIDTH){1'b0}});
    end

    // Control FSM, accumulator, flags and handshake pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            acc_r    <= {WIDTH{1'b0}};
            flag_z_r <= 1'b0;
            flag_c_r <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            rf_wr_r  <= 1'b0;
            mcand_r  <= {WIDTH{1'b0}};
            mplr_r   <= {WIDTH{1'b0}};
            prod_r   <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            done_r  <= 1'b0;
            rf_wr_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            mcand_r <= acc_r;
                            mplr_r  <= operand;
                            prod_r  <= {(2*WIDTH){1'b0}};
                            cnt_r   <= {CW{1'b0}};
                            busy_r  <= 1'b1;
                            state_r <= ST_MUL;
                        end else begin
                            acc_r    <= alu_acc_s;
                            flag_z_r <= alu_z_s;
                            flag_c_r <= alu_c_s;
                            done_r   <= 1'b1;
                            rf_wr_r  <= (op == OP_STA);
                        end
                    end
                end
                ST_MUL: begin
                    prod_r <= prod_step_s;
                    mplr_r <= {1'b0, mplr_r[WIDTH-1:1]};
                    cnt_r  <= cnt_r + CW'(1);
                    // Last step: the product is final including this step's addend
                    if (cnt_r == CNT_LAST) begin
                        acc_r    <= prod_step_s[WIDTH-1:0];
                        flag_c_r <= |prod_step_s[2*WIDTH-1:WIDTH];
                        flag_z_r <= (prod_step_s[WIDTH-1:0] == {WIDTH{1'b0}});
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc.sv
// Bench for alu_acc: directed scenarios with literal expectations plus a random
// run, all checked every cycle against a plain-arithmetic accumulator model.
module tb_alu_acc;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] operand;
    logic         busy;
    logic         done;
    logic [W-1:0] acc_out;
    logic         rf_wr;
    logic         flag_z;
    logic         flag_c;

    int n_checks = 0;
    int n_fail   = 0;

    alu_acc #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .operand (operand),
        .busy    (busy),
        .done    (done),
        .acc_out (acc_out),
        .rf_wr   (rf_wr),
        .flag_z  (flag_z),
        .flag_c  (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected visible outputs after each rising edge
    logic [W-1:0] m_acc;
    logic         m_z, m_c, m_done, m_busy, m_wr;
    bit           m_valid = 1'b0;
    int           mul_left;
    int unsigned  mul_a, mul_b, prod;
    logic [W:0]   sum;

    always @(posedge clk) begin
        if (rst) begin
            m_acc = '0; m_z = 1'b0; m_c = 1'b0;
            m_done = 1'b0; m_busy = 1'b0; m_wr = 1'b0;
            mul_left = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_done = 1'b0;
            m_wr   = 1'b0;
            if (m_busy) begin
                mul_left--;
                if (mul_left == 0) begin
                    prod   = mul_a * mul_b;
                    m_acc  = prod[W-1:0];
                    m_c    = (prod >> W) != 0;
                    m_z    = (m_acc == 0);
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (start) begin
                m_done = 1'b1;
                case (op)
                    4'd1: begin m_acc = operand; m_z = (m_acc == 0); end
                    4'd2: begin
                        sum   = m_acc + operand;
                        m_c   = sum[W];
                        m_acc = sum[W-1:0];
                        m_z   = (m_acc == 0);
                    end
                    4'd3: begin
                        m_c   = (operand > m_acc);
                        m_acc = m_acc - operand;
                        m_z   = (m_acc == 0);
                    end
                    4'd4: begin m_acc = m_acc & operand; m_c = 1'b0; m_z = (m_acc == 0); end
                    4'd5: begin m_acc = m_acc | operand; m_c = 1'b0; m_z = (m_acc == 0); end
                    4'd6: begin m_acc = m_acc ^ operand; m_c = 1'b0; m_z = (m_acc == 0); end
                    4'd7: begin m_c = m_acc[W-1]; m_acc = m_acc << 1; m_z = (m_acc == 0); end
                    4'd8: begin m_c = m_acc[0];   m_acc = m_acc >> 1; m_z = (m_acc == 0); end
                    4'd9: begin
                        mul_a    = m_acc;
                        mul_b    = operand;
                        mul_left = W;
                        m_busy   = 1'b1;
                        m_done   = 1'b0;
                    end
                    4'd10: m_wr = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("acc",   acc_out, m_acc);
            check("z",     W'(flag_z), W'(m_z));
            check("c",     W'(flag_c), W'(m_c));
            check("done",  W'(done),   W'(m_done));
            check("busy",  W'(busy),   W'(m_busy));
            check("rf_wr", W'(rf_wr),  W'(m_wr));
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] v);
        start = 1'b1; op = o; operand = v;
        @(negedge clk);
        start = 1'b0; op = 4'd0; operand = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_timeout actual=busy required=idle t=%0t", $time);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 4'd0; operand = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_acc",  acc_out, 8'h00);
        check("rst_done", W'(done), 8'h00);
        check("rst_busy", W'(busy), 8'h00);
        rst = 1'b0;
        @(negedge clk);

        issue(4'd1, 8'h7F);
        check("lda_done", W'(done), 8'h01);
        issue(4'd2, 8'h01);
        check("add_acc",  acc_out, 8'h80);
        check("add_c",    W'(flag_c), 8'h00);
        check("add_done", W'(done), 8'h01);

        issue(4'd1, 8'h01);
        issue(4'd2, 8'hFF);
        check("addwrap_acc", acc_out, 8'h00);
        check("addwrap_cz",  {6'd0, flag_c, flag_z}, 8'h03);

        issue(4'd1, 8'h03);
        issue(4'd3, 8'h05);
        check("sub_acc", acc_out, 8'hFE);
        check("sub_cz",  {6'd0, flag_c, flag_z}, 8'h02);

        issue(4'd1, 8'h0C);
        issue(4'd9, 8'h0D);
        for (int i = 1; i < W; i++) begin
            check("mul_busy", W'(busy), 8'h01);
            @(negedge clk);
        end
        check("mul_busy_last", W'(busy), 8'h01);
        @(negedge clk);
        check("mul_acc",  acc_out, 8'h9C);
        check("mul_done", W'(done), 8'h01);
        check("mul_c",    W'(flag_c), 8'h00);

        issue(4'd1, 8'h10);
        issue(4'd9, 8'h10);
        wait_idle();
        check("mulovf_acc", acc_out, 8'h00);
        check("mulovf_cz",  {6'd0, flag_c, flag_z}, 8'h03);

        issue(4'd1, 8'h05);
        issue(4'd9, 8'h07);
        @(negedge clk);
        issue(4'd1, 8'h55);
        wait_idle();
        check("mul_ignore_acc", acc_out, 8'h23);

        issue(4'd1, 8'hA5);
        issue(4'd10, 8'h00);
        check("sta_wr",  W'(rf_wr), 8'h01);
        check("sta_acc", acc_out, 8'hA5);
        @(negedge clk);
        check("sta_wr_off", W'(rf_wr), 8'h00);

        // Reset sampled on the fourth multiply step
        issue(4'd1, 8'h0F);
        issue(4'd9, 8'h0F);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmul_busy", W'(busy), 8'h00);
        check("rstmul_done", W'(done), 8'h00);
        check("rstmul_acc",  acc_out, 8'h00);
        check("rstmul_flags", {6'd0, flag_c, flag_z}, 8'h00);
        issue(4'd1, 8'h3C);
        check("post_rst_lda", acc_out, 8'h3C);

        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 79) == 0);
            start   = ($urandom_range(0, 9) < 6);
            op      = 4'($urandom_range(0, 15));
            operand = W'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0;
        repeat (W + 2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
